seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-segment 7-segment digits. It drives one shared segment decoder: each cycle it presents the display code for the currently active digit and a one-hot digit-select. It holds a double-buffered frame of digit codes, swaps buffers only at frame boundaries so the display never tears, and inserts a blanking gap before every digit to suppress ghosting. It sits between the system logic that produces digit values and the segment decoder / digit-enable pins.

## Interface
- `NDIG`, default 8: number of digits scanned; legal range 1..8.
- `DIV`, default 50000: clock cycles per digit slot; must satisfy `DIV > BLANK`.
- `BLANK`, default 4: blanking cycles at the start of each slot; must be ≥ 1.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: single-cycle request to write a new frame.
- `load_data` in 8*NDIG: new frame; byte i (bits 8i+7:8i) is the code for digit i.
  - Codes: 0..9 show a digit; 10..19 show the same digit plus the decimal point; 20 is blank.
- `num` out 8: code for the active digit, fed to the segment decoder.
- `dig_sel` out NDIG: one-hot, active-high enable for the active digit; all zero while blanking.
- `load_pend` out 1: high while an accepted frame is waiting for the next frame boundary.
- `frame_done` out 1: one-cycle pulse on the last cycle of digit NDIG-1.

## Operation
- **Storage.** Two registers of NDIG bytes each:
  - `shadow`: written by `load`.
  - `disp`: the buffer being scanned.
- **Slot counter.** `cnt` counts 0..DIV-1 and wraps. `idx` (digit index) advances when `cnt == DIV-1` and wraps from NDIG-1 to 0.
- **Two phases per slot:**
  - BLANK (`cnt < BLANK`): `dig_sel = 0`, `num = 20`.
  - SHOW (`cnt ≥ BLANK`): `dig_sel = onehot(idx)`, `num = disp[idx]`.
- **Load accept.** `load` is accepted on any cycle; there is no back-pressure.
  - `shadow <= load_data` and `load_pend <= 1`.
  - Multiple loads within one frame: the last one wins.
- **Frame boundary** (`cnt == DIV-1` and `idx == NDIG-1`):
  - `frame_done = 1`.
  - If `load_pend` is set: `disp <= shadow`, `load_pend <= 0`.
  - If `load` is also asserted on this same cycle: `disp <= load_data` directly (newest wins) and `load_pend` ends at 0.
- **Code handling.** Codes above 20 pass through unmodified; the decoder handles them.
- **Reset values.** `cnt=0`, `idx=0`, `disp` all 20, `shadow` all 20, `num=20`, `dig_sel=0`, `load_pend=0`, `frame_done=0`.
- **Reset mid-operation.** A reset during a frame discards any pending frame; scanning restarts at digit 0 in the BLANK phase.

## Timing
- All outputs are registered. `num` and `dig_sel` reflect `cnt`/`idx` with one cycle of latency, uniformly, so slot phases are exact:
  - Each slot is DIV cycles.
  - The first BLANK cycles of every slot are blank.
  - The remaining DIV-BLANK cycles show the digit.
- After reset is released:
  - Digit 0 begins showing on output cycle BLANK+1.
  - A full frame lasts NDIG*DIV cycles.
- Load-to-display latency: from the `load` cycle to the next frame boundary, plus BLANK+1 cycles, until digit 0 shows the new data.
  - Worst case: NDIG*DIV + BLANK + 1 cycles.
- `frame_done` is asserted in the same output cycle as the last SHOW cycle of digit NDIG-1.
- With NDIG=1 every slot end is a frame boundary.

## Configuration
- Macro `SEG_SCAN_LZ_SUPPRESS_EN`.
- **Defined:** leading-zero suppression at display time.
  - Scanning from digit NDIG-1 down, each digit whose code is 0 is shown as 20 until the first code that is not 0 and not 20.
  - Digit 0 is never suppressed.
  - Codes 10 (zero with decimal point) stop suppression.
  - Implemented as a combinational mask over `disp`, recomputed whenever `disp` changes; it does not affect timing.
- **Undefined:** `disp[idx]` is output unaltered.

## Structure
- **Package `seg_pkg`** holds:
  - `SEG_BLANK_CODE = 20`
  - `SEG_DP_OFFSET = 10`
  - `SEG_CODE_W = 8`
  - the type `seg_code_t` (8-bit display code).
- **Sub-module `seg_scan_timer`:**
  - Contains the `cnt`/`idx` counters.
  - Outputs `slot_end`, `frame_end` and `in_blank`.
  - The parent holds the buffers, the load logic and the output registers.

## Test plan
Bench parameters: NDIG=4, DIV=8, BLANK=2.
1. **Reset.** Hold `rst_n=0` for 5 cycles, then release → `num=20` and `dig_sel=0000` for 2 cycles, then `dig_sel=0001` with `num=20` (buffer blank); `frame_done` pulses every 32 cycles.
2. **Basic load.** `load` with data {3,2,1,0} → `load_pend=1` until the frame boundary, then the slots show num 0,1,2,3 with `dig_sel` 0001, 0010, 0100, 1000, each for 6 cycles after 2 blank cycles.
3. **Last load wins.** Two loads in one frame, {9,9,9,9} then {5,6,7,8} → the next frame shows 8,7,6,5; 9 never appears.
4. **Load on boundary.** `load` asserted on the `frame_done` cycle with {10,11,12,13} → the very next slot shows `num=13`; `load_pend` stays 0.
5. **Reset mid-frame.** `load` pending, then assert `rst_n` low during digit 2 → after release `load_pend=0` and all digits show 20.
6. **Leading-zero suppression** (`SEG_SCAN_LZ_SUPPRESS_EN` defined). Data {0,0,4,0} (digit3..digit0) → digits 3 and 2 show 20, digit 1 shows 4, digit 0 shows 0. Data {0,0,0,0} → only digit 0 shows 0.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared display-code constants and types for the segment scan controller.
package seg_pkg;
    localparam int SEG_CODE_W = 8;
    typedef logic [SEG_CODE_W-1:0] seg_code_t;
    localparam seg_code_t SEG_BLANK_CODE = 8'd20;
    localparam seg_code_t SEG_DP_OFFSET = 8'd10;
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot cycle counter and digit index, with slot/frame/blank qualifiers.
module seg_scan_timer #(
    parameter int NDIG = 8,
    parameter int DIV = 50000,
    parameter int BLANK = 4,
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1,
    localparam int CW = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx,
    output logic          slot_end,
    output logic          frame_end,
    output logic          in_blank
);
    logic [CW-1:0] cnt;
    assign slot_end = cnt == CW'(DIV - 1);
    assign frame_end = slot_end && idx == IW'(NDIG - 1);
    assign in_blank = cnt < CW'(BLANK);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= frame_end ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered multiplexed 7-segment scan controller with per-digit blanking.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG = 8,
    parameter int DIV = 50000,
    parameter int BLANK = 4,
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [SEG_CODE_W*NDIG-1:0] load_data,
    output seg_code_t                  num,
    output logic [NDIG-1:0]            dig_sel,
    output logic                       load_pend,
    output logic                       frame_done
);
    logic [IW-1:0] idx;
    logic slot_end, frame_end, in_blank, boundary;
    logic [SEG_CODE_W*NDIG-1:0] shadow, disp, view;

    seg_scan_timer #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .idx(idx),
        .slot_end(slot_end),
        .frame_end(frame_end),
        .in_blank(in_blank)
    );

    assign boundary = slot_end & frame_end;

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    // Zeros are blanked from the top digit down until a visible code; 20 keeps suppression alive.
    always_comb begin
        logic sup;
        view = disp;
        sup = 1'b1;
        for (int i = NDIG - 1; i > 0; i--) begin
            if (sup && disp[SEG_CODE_W*i +: SEG_CODE_W] == '0)
                view[SEG_CODE_W*i +: SEG_CODE_W] = SEG_BLANK_CODE;
            else if (disp[SEG_CODE_W*i +: SEG_CODE_W] != SEG_BLANK_CODE)
                sup = 1'b0;
        end
    end
`else
    assign view = disp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= {NDIG{SEG_BLANK_CODE}};
            disp <= {NDIG{SEG_BLANK_CODE}};
            load_pend <= 1'b0;
            num <= SEG_BLANK_CODE;
            dig_sel <= '0;
            frame_done <= 1'b0;
        end else begin
            if (load)
                shadow <= load_data;
            // A load coinciding with the boundary bypasses shadow so the newest frame wins.
            disp <= boundary && load ? load_data : (boundary && load_pend ? shadow : disp);
            load_pend <= boundary ? 1'b0 : load | load_pend;
            num <= in_blank ? SEG_BLANK_CODE : view[SEG_CODE_W*idx +: SEG_CODE_W];
            dig_sel <= in_blank ? '0 : NDIG'(1) << idx;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table-driven frame checks plus a per-cycle scoreboard for seg_scan_ctrl.
module tb_seg_scan_ctrl;
    import seg_pkg::*;
    localparam int NDIG = 4;
    localparam int DIV = 8;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic [31:0] load_data = '0;
    seg_code_t num;
    logic [3:0] dig_sel;
    logic load_pend, frame_done;

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .load_data(load_data),
        .num(num),
        .dig_sel(dig_sel),
        .load_pend(load_pend),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] num;
        logic [3:0] sel;
        logic       pend;
        logic       fd;
    } exp_t;

    typedef struct {
        int              mode;
        logic [31:0]     pre;
        logic [31:0]     data;
        logic [3:0][7:0] exp;
    } vec_t;

    exp_t q[$];
    vec_t vecs[8];
    int n_chk = 0;
    int n_fail = 0;
    int m_cnt, m_idx;
    logic [31:0] m_disp, m_shadow;
    logic m_pend;
    logic chk_en = 1'b0;
    logic [3:0][7:0] cur_exp;

    function automatic logic [31:0] lz(input logic [31:0] d);
        logic [31:0] r;
        r = d;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        begin
            bit s;
            s = 1'b1;
            for (int i = 3; i > 0; i--) begin
                if (s && d[8*i +: 8] == 8'd0) r[8*i +: 8] = 8'd20;
                else if (d[8*i +: 8] != 8'd20) s = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        m_disp = {4{8'd20}};
        m_shadow = {4{8'd20}};
        m_pend = 1'b0;
    endtask

    task automatic tick();
        exp_t e;
        logic [31:0] v;
        v = lz(m_disp);
        e.num = m_cnt < BLANK ? 8'd20 : v[8*m_idx +: 8];
        e.sel = m_cnt < BLANK ? 4'b0 : 4'b1 << m_idx;
        e.fd = m_cnt == DIV - 1 && m_idx == NDIG - 1;
        if (e.fd && load) m_disp = load_data;
        else if (e.fd && m_pend) m_disp = m_shadow;
        if (load) m_shadow = load_data;
        m_pend = e.fd ? 1'b0 : (m_pend | load);
        e.pend = m_pend;
        if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx == NDIG - 1) ? 0 : m_idx + 1;
        end else m_cnt++;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("num", num, e.num);
        check("dig_sel", dig_sel, e.sel);
        check("load_pend", load_pend, e.pend);
        check("frame_done", frame_done, e.fd);
        if (chk_en && e.sel != 0)
            for (int d = 0; d < 4; d++)
                if (e.sel[d]) check("vec_num", num, cur_exp[d]);
    endtask

    task automatic wait_pos(input int c, input int i);
        int k;
        k = 0;
        while (!(m_cnt == c && m_idx == i) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pos: timeout waiting for cnt=%0d idx=%0d", c, i);
        end
    endtask

    task automatic check_frame(input logic [3:0][7:0] ex);
        cur_exp = ex;
        chk_en = 1'b1;
        repeat (NDIG * DIV) tick();
        chk_en = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] d);
        load = 1'b1;
        load_data = d;
        tick();
        load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 32'h0, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd3, 8'd2, 8'd1, 8'd0}};
        vecs[1] = '{2, {4{8'd9}}, {8'd5, 8'd6, 8'd7, 8'd8}, {8'd5, 8'd6, 8'd7, 8'd8}};
        vecs[2] = '{1, 32'h0, {SEG_DP_OFFSET, SEG_DP_OFFSET + 8'd1, SEG_DP_OFFSET + 8'd2, SEG_DP_OFFSET + 8'd3},
                    {8'd10, 8'd11, 8'd12, 8'd13}};
        vecs[5] = '{0, 32'h0, {8'd21, 8'd20, 8'd0, 8'd7}, {8'd21, 8'd20, 8'd0, 8'd7}};
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        vecs[3] = '{0, 32'h0, {8'd0, 8'd0, 8'd4, 8'd0}, {8'd20, 8'd20, 8'd4, 8'd0}};
        vecs[4] = '{0, 32'h0, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd20, 8'd20, 8'd20, 8'd0}};
        vecs[6] = '{0, 32'h0, {8'd0, 8'd20, 8'd0, 8'd5}, {8'd20, 8'd20, 8'd20, 8'd5}};
        vecs[7] = '{0, 32'h0, {8'd0, 8'd10, 8'd0, 8'd1}, {8'd20, 8'd10, 8'd0, 8'd1}};
`else
        vecs[3] = '{0, 32'h0, {8'd0, 8'd0, 8'd4, 8'd0}, {8'd0, 8'd0, 8'd4, 8'd0}};
        vecs[4] = '{0, 32'h0, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[6] = '{0, 32'h0, {8'd0, 8'd20, 8'd0, 8'd5}, {8'd0, 8'd20, 8'd0, 8'd5}};
        vecs[7] = '{0, 32'h0, {8'd0, 8'd10, 8'd0, 8'd1}, {8'd0, 8'd10, 8'd0, 8'd1}};
`endif

        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check("rst_num", num, 8'd20);
        check("rst_dig_sel", dig_sel, 4'b0);
        check("rst_load_pend", load_pend, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame({4{8'd20}});
        repeat (NDIG * DIV) tick();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].mode == 1) begin
                wait_pos(DIV - 1, NDIG - 1);
                do_load(vecs[v].data);
                check("boundary_pend", load_pend, 1'b0);
            end else begin
                wait_pos(0, 0);
                if (vecs[v].mode == 2) do_load(vecs[v].pre);
                do_load(vecs[v].data);
                check("load_pend_set", load_pend, 1'b1);
                wait_pos(0, 0);
            end
            check_frame(vecs[v].exp);
        end

        wait_pos(0, 0);
        do_load({8'd1, 8'd2, 8'd3, 8'd4});
        wait_pos(2, 2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_num", num, 8'd20);
        check("mid_rst_dig_sel", dig_sel, 4'b0);
        check("mid_rst_load_pend", load_pend, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame({4{8'd20}});
        check_frame({4{8'd20}});
        check("mid_rst_pend_after", load_pend, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
